// File: rtl/cs_resolve_seq.sv
// cs_resolve_seq: resolves a carry-save pair into one binary result, CHUNK_W bits per clock.
// Optional macro CS_RESOLVE_BACK2BACK_EN lets DONE retire a result and accept a new pair in one cycle.
module cs_resolve_seq #(
   parameter int unsigned DW      = 16,
   parameter int unsigned CHUNK_W = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_vld,
   output logic          o_rdy,
   input  logic [DW-1:0] i_sum,
   input  logic [DW-1:0] i_carry,
   output logic          o_vld,
   input  logic          i_rdy,
   output logic [DW-1:0] o_res,
   output logic          o_cout
);

   localparam int unsigned NCHUNK = (DW + CHUNK_W - 1) / CHUNK_W;
   localparam int unsigned PW     = NCHUNK * CHUNK_W;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [PW-1:0]      opa;
   logic [PW-1:0]      opb;
   logic [PW-1:0]      acc;
   logic               c_q;
   logic [IW-1:0]      idx;
   logic               vld_q;
   logic [DW-1:0]      res_q;
   logic               cout_q;

   logic               load;
   logic [CHUNK_W:0]   csum;
   logic [31:0]        shamt;
   logic [PW-1:0]      acc_nxt;
   logic [PW:0]        full;

`ifdef CS_RESOLVE_BACK2BACK_EN
   assign o_rdy = (state == IDLE) | ((state == DONE) & i_rdy);
`else
   assign o_rdy = (state == IDLE);
`endif

   assign load   = i_vld & o_rdy;
   assign o_vld  = vld_q;
   assign o_res  = res_q;
   assign o_cout = cout_q;

   // Operands are zero-padded to whole chunks, so the carry out of bit DW-1 lands at
   // bit DW of the padded sum and every bit above it stays zero.
   always_comb begin
      csum    = {1'b0, opa[CHUNK_W-1:0]} + {1'b0, opb[CHUNK_W-1:0]} + {{CHUNK_W{1'b0}}, c_q};
      shamt   = 32'(idx) * CHUNK_W;
      acc_nxt = acc | (PW'(csum[CHUNK_W-1:0]) << shamt);
      full    = {csum[CHUNK_W], acc_nxt};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         c_q    <= 1'b0;
         idx    <= '0;
         vld_q  <= 1'b0;
         res_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               opa <= opa >> CHUNK_W;
               opb <= opb >> CHUNK_W;
               acc <= acc_nxt;
               c_q <= csum[CHUNK_W];
               idx <= idx + 1'b1;
               if (idx == IW'(NCHUNK - 1)) begin
                  res_q  <= full[DW-1:0];
                  cout_q <= |full[PW:DW];
                  vld_q  <= 1'b1;
                  idx    <= '0;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (i_rdy) begin
                  vld_q <= 1'b0;
                  state <= IDLE;
               end
            end
            IDLE: ;
            default: state <= IDLE;
         endcase
         // A retire-and-accept in DONE overrides the IDLE transition above.
         if (load) begin
            opa   <= PW'(i_sum);
            opb   <= PW'(i_carry);
            acc   <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
            state <= CALC;
         end
      end
   end

endmodule

// File: tb/tb_cs_resolve_seq.sv
// Directed and scoreboarded bench for cs_resolve_seq over several DW/CHUNK_W configurations.
module tb_cs_resolve_seq;

   typedef struct {
      logic [15:0] s;
      logic [15:0] c;
      logic [15:0] r;
      logic        co;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        vld_i  [4];
   logic        rdy_i  [4];
   logic        rdy_o  [4];
   logic        vld_o  [4];
   logic        cout_o [4];
   logic [15:0] sum_i  [4];
   logic [15:0] car_i  [4];
   logic [15:0] res_o  [4];

   logic        vld10_i, rdy10_i, rdy10_o, vld10_o, cout10_o;
   logic [9:0]  sum10_i, car10_i, res10_o;

   int          nvec = 0;
   int          nmis = 0;
   int          ncyc [4] = '{4, 16, 6, 1};
   vec_t        tbl [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cs_resolve_seq #(.DW(16), .CHUNK_W(4)) u_c4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_i[0]), .o_rdy(rdy_o[0]), .i_sum(sum_i[0]),
      .i_carry(car_i[0]), .o_vld(vld_o[0]), .i_rdy(rdy_i[0]), .o_res(res_o[0]), .o_cout(cout_o[0]));
   cs_resolve_seq #(.DW(16), .CHUNK_W(1)) u_c1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_i[1]), .o_rdy(rdy_o[1]), .i_sum(sum_i[1]),
      .i_carry(car_i[1]), .o_vld(vld_o[1]), .i_rdy(rdy_i[1]), .o_res(res_o[1]), .o_cout(cout_o[1]));
   cs_resolve_seq #(.DW(16), .CHUNK_W(3)) u_c3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_i[2]), .o_rdy(rdy_o[2]), .i_sum(sum_i[2]),
      .i_carry(car_i[2]), .o_vld(vld_o[2]), .i_rdy(rdy_i[2]), .o_res(res_o[2]), .o_cout(cout_o[2]));
   cs_resolve_seq #(.DW(16), .CHUNK_W(16)) u_c16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_i[3]), .o_rdy(rdy_o[3]), .i_sum(sum_i[3]),
      .i_carry(car_i[3]), .o_vld(vld_o[3]), .i_rdy(rdy_i[3]), .o_res(res_o[3]), .o_cout(cout_o[3]));
   cs_resolve_seq #(.DW(10), .CHUNK_W(4)) u_d10 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld10_i), .o_rdy(rdy10_o), .i_sum(sum10_i),
      .i_carry(car10_i), .o_vld(vld10_o), .i_rdy(rdy10_i), .o_res(res10_o), .o_cout(cout10_o));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One operation: handshake, latency, result, optional backpressure hold, retire.
   task automatic do_op(input int k, input logic [15:0] s, input logic [15:0] c,
                        input logic [15:0] er, input logic ec, input int hold, input string nm);
      int n;
      @(negedge clk);
      sum_i[k] = s; car_i[k] = c; vld_i[k] = 1'b1; rdy_i[k] = 1'b0;
      n = 0;
      while (!rdy_o[k] && n < 50) begin @(negedge clk); n++; end
      chk({nm, " accept"}, 32'(rdy_o[k]), 32'd1);
      @(negedge clk);
      vld_i[k] = 1'b0; sum_i[k] = ~s; car_i[k] = 16'h5A5A;
      n = 0;
      while (!vld_o[k] && n < 60) begin @(negedge clk); n++; end
      chk({nm, " latency"}, 32'(n), 32'(ncyc[k]));
      chk({nm, " res"}, 32'(res_o[k]), 32'(er));
      chk({nm, " cout"}, 32'(cout_o[k]), 32'(ec));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, " hold res"}, 32'(res_o[k]), 32'(er));
         chk({nm, " hold cout"}, 32'(cout_o[k]), 32'(ec));
         chk({nm, " hold vld/rdy"}, {30'd0, vld_o[k], rdy_o[k]}, 32'b10);
      end
      rdy_i[k] = 1'b1;
      @(negedge clk);
      rdy_i[k] = 1'b0;
      chk({nm, " retire vld/rdy"}, {30'd0, vld_o[k], rdy_o[k]}, 32'b01);
      chk({nm, " res kept"}, 32'(res_o[k]), 32'(er));
   endtask

   task automatic rand_run(input int k, input int nops);
      logic [16:0] q[$];
      logic [16:0] e;
      int          sent = 0, got = 0, cyc = 0;
      logic        acc_d = 1'b1;
      while (got < nops && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc_d || !vld_i[k]) begin
            vld_i[k] = (sent < nops) && ($urandom_range(0, 3) != 0);
            sum_i[k] = 16'($urandom);
            car_i[k] = 16'($urandom);
         end
         rdy_i[k] = ($urandom_range(0, 2) != 0);
         #1;
         acc_d = vld_i[k] && rdy_o[k];
         if (acc_d) begin
            q.push_back({1'b0, sum_i[k]} + {1'b0, car_i[k]});
            sent++;
         end
         if (vld_o[k] && rdy_i[k]) begin
            if (q.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL T6 k=%0d spurious result: got %h, expected none", k, res_o[k]);
            end else begin
               e = q.pop_front();
               chk($sformatf("T6 k=%0d res", k), 32'(res_o[k]), 32'(e[15:0]));
               chk($sformatf("T6 k=%0d cout", k), 32'(cout_o[k]), 32'(e[16]));
            end
            got++;
         end
      end
      chk($sformatf("T6 k=%0d results", k), 32'(got), 32'(nops));
      chk($sformatf("T6 k=%0d pending", k), 32'(q.size()), 32'd0);
      vld_i[k] = 1'b0; rdy_i[k] = 1'b0;
   endtask

   initial begin
      int          n, sent, got, cyc, prev, spacing;
      logic [16:0] q[$];
      logic [16:0] e;
      logic        newp;

      tbl[0] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      tbl[1] = '{16'h1234, 16'h0F0F, 16'h2143, 1'b0};
      tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
      tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
      tbl[4] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};
      tbl[5] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
      tbl[7] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};

      for (int k = 0; k < 4; k++) begin
         vld_i[k] = 1'b0; rdy_i[k] = 1'b0; sum_i[k] = '0; car_i[k] = '0;
      end
      vld10_i = 1'b0; rdy10_i = 1'b0; sum10_i = '0; car10_i = '0;

      // Reset state, with a valid request that must be ignored.
      rst_n = 1'b0;
      vld_i[0] = 1'b1; sum_i[0] = 16'h1111; car_i[0] = 16'h2222;
      #2;
      chk("reset vld/rdy", {30'd0, vld_o[0], rdy_o[0]}, 32'b01);
      chk("reset res", 32'(res_o[0]), 32'd0);
      chk("reset cout", 32'(cout_o[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("reset held vld", 32'(vld_o[0]), 32'd0);
      vld_i[0] = 1'b0;
      rst_n = 1'b1;

      // Table vectors on every 16-bit configuration; T2 hold on CHUNK_W=4.
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++)
            do_op(k, tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].co,
                  (k == 0 && i == 1) ? 10 : 0, $sformatf("vec k=%0d i=%0d", k, i));

      // T3: DW=10, partial last chunk.
      @(negedge clk);
      sum10_i = 10'h3FF; car10_i = 10'h3FF; vld10_i = 1'b1;
      chk("T3 accept", 32'(rdy10_o), 32'd1);
      @(negedge clk);
      vld10_i = 1'b0; sum10_i = '0; car10_i = '0;
      n = 0;
      while (!vld10_o && n < 20) begin @(negedge clk); n++; end
      chk("T3 latency", 32'(n), 32'd3);
      chk("T3 res", 32'(res10_o), 32'h3FE);
      chk("T3 cout", 32'(cout10_o), 32'd1);
      rdy10_i = 1'b1;
      @(negedge clk);
      rdy10_i = 1'b0;
      chk("T3 retire", {30'd0, vld10_o, rdy10_o}, 32'b01);

      // T4: reset during the second CALC cycle, then a clean operation.
      @(negedge clk);
      sum_i[0] = 16'hFFFF; car_i[0] = 16'h0001; vld_i[0] = 1'b1;
      @(negedge clk);
      vld_i[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("T4 vld/rdy", {30'd0, vld_o[0], rdy_o[0]}, 32'b01);
      chk("T4 res", 32'(res_o[0]), 32'd0);
      chk("T4 cout", 32'(cout_o[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, "T4 after");
      do_op(0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0, "T4 after2");

      // T5: back-to-back stream with i_vld and i_rdy held high.
`ifdef CS_RESOLVE_BACK2BACK_EN
      spacing = 5;
`else
      spacing = 6;
`endif
      sent = 0; got = 0; cyc = 0; prev = -1; newp = 1'b0;
      @(negedge clk);
      sum_i[0] = 16'($urandom); car_i[0] = 16'($urandom); vld_i[0] = 1'b1; rdy_i[0] = 1'b1;
      while (got < 8 && cyc < 300) begin
         #1;
         if (vld_o[0]) begin
            if (q.size() != 0) begin
               e = q.pop_front();
               chk($sformatf("T5 res %0d", got), 32'(res_o[0]), 32'(e[15:0]));
               chk($sformatf("T5 cout %0d", got), 32'(cout_o[0]), 32'(e[16]));
            end else begin
               nvec++; nmis++;
               $display("FAIL T5 spurious result: got %h, expected none", res_o[0]);
            end
            if (prev >= 0) chk($sformatf("T5 spacing %0d", got), 32'(cyc - prev), 32'(spacing));
            prev = cyc;
            got++;
         end
         if (vld_i[0] && rdy_o[0]) begin
            q.push_back({1'b0, sum_i[0]} + {1'b0, car_i[0]});
            sent++;
            newp = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (newp) begin
            newp = 1'b0;
            if (sent < 8) begin
               sum_i[0] = 16'($urandom); car_i[0] = 16'($urandom);
            end else vld_i[0] = 1'b0;
         end
      end
      chk("T5 results", 32'(got), 32'd8);
      vld_i[0] = 1'b0; rdy_i[0] = 1'b0;
      @(negedge clk);

      // T6: random valid/ready toggling on every 16-bit configuration.
      for (int k = 0; k < 4; k++) rand_run(k, 250);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
